// File: rtl/jt51_pkg.sv
// Shared constants for the JT51 operator accumulator: frame geometry, widths,
// and the algorithm-to-carrier lookup.
package jt51_pkg;

   localparam int unsigned SLOTS  = 32;
   localparam int unsigned ACC_W  = 19;
   localparam int unsigned OP_W   = 14;
   localparam int unsigned SLOT_W = $clog2(SLOTS);

   typedef enum logic [1:0] {
      GRP_M1 = 2'd0,
      GRP_M2 = 2'd1,
      GRP_C1 = 2'd2,
      GRP_C2 = 2'd3
   } grp_e;

   // Row = algorithm (con), bit = operator group; 1 marks a carrier.
   localparam logic [7:0][3:0] CARRIER_TBL = {
      4'b1111,  // con 7
      4'b1110,  // con 6
      4'b1110,  // con 5
      4'b1100,  // con 4
      4'b1000,  // con 3
      4'b1000,  // con 2
      4'b1000,  // con 1
      4'b1000   // con 0
   };

   function automatic logic is_carrier(input logic [2:0] con, input grp_e grp);
      return CARRIER_TBL[con][grp];
   endfunction

endpackage

// File: rtl/jt51_opacc_sat.sv
// Signed clamp of a wide accumulator sum into the output sample range.
module jt51_opacc_sat #(
   parameter int IN_W  = 19,
   parameter int OUT_W = 16
) (
   input  logic signed [IN_W-1:0]  i_sum,
   output logic signed [OUT_W-1:0] o_sat
);

   localparam logic signed [IN_W-1:0] MAX = IN_W'((1 << (OUT_W-1)) - 1);
   localparam logic signed [IN_W-1:0] MIN = ~MAX;

   always_comb begin
      if (i_sum > MAX)
         o_sat = MAX[OUT_W-1:0];
      else if (i_sum < MIN)
         o_sat = MIN[OUT_W-1:0];
      else
         o_sat = i_sum[OUT_W-1:0];
   end

endmodule

// File: rtl/jt51_opacc.sv
// Per-frame accumulation of carrier operator outputs into saturated
// left/right samples, strobed once per 32-slot frame.
module jt51_opacc
   import jt51_pkg::*;
#(
   parameter int OUT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cen,
   input  logic                    zero,
   input  logic signed [OP_W-1:0]  op_in,
   input  logic [2:0]              con,
   input  logic [1:0]              rl,
   input  logic                    ne,
   input  logic signed [OP_W-1:0]  noise_in,
   output logic signed [OUT_W-1:0] left,
   output logic signed [OUT_W-1:0] right,
   output logic                    sample
);

   logic [SLOT_W-1:0]        r_cnt;
   logic                     r_synced;
   logic signed [ACC_W-1:0]  r_acc_l, r_acc_r;
   logic signed [OUT_W-1:0]  r_left, r_right;
   logic                     r_sample;

   logic [SLOT_W-1:0]        w_slot;
   grp_e                     w_grp;
   logic                     w_first, w_last, w_active, w_carrier;
   logic signed [OP_W-1:0]   w_src;
   logic signed [ACC_W-1:0]  w_ext, w_add_l, w_add_r, w_sum_l, w_sum_r;
   logic signed [OUT_W-1:0]  w_sat_l, w_sat_r;

   always_comb begin
      w_slot    = zero ? '0 : r_cnt;
      w_grp     = grp_e'(w_slot[SLOT_W-1 -: 2]);
      w_first   = (w_slot == '0);
      w_last    = (w_slot == SLOT_W'(SLOTS-1));
      // Before the first frame marker nothing is accumulated or emitted.
      w_active  = zero | r_synced;
      w_src     = (w_last && ne) ? noise_in : op_in;
      w_ext     = {{(ACC_W-OP_W){w_src[OP_W-1]}}, w_src};
      w_carrier = is_carrier(con, w_grp);
      w_add_l   = (w_carrier && rl[0]) ? w_ext : '0;
      w_add_r   = (w_carrier && rl[1]) ? w_ext : '0;
      w_sum_l   = (w_first ? '0 : r_acc_l) + w_add_l;
      w_sum_r   = (w_first ? '0 : r_acc_r) + w_add_r;
   end

   jt51_opacc_sat #(.IN_W(ACC_W), .OUT_W(OUT_W)) u_sat_l (
      .i_sum (w_sum_l),
      .o_sat (w_sat_l)
   );

   jt51_opacc_sat #(.IN_W(ACC_W), .OUT_W(OUT_W)) u_sat_r (
      .i_sum (w_sum_r),
      .o_sat (w_sat_r)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt    <= '0;
         r_synced <= 1'b0;
         r_acc_l  <= '0;
         r_acc_r  <= '0;
         r_left   <= '0;
         r_right  <= '0;
         r_sample <= 1'b0;
      end else if (cen) begin
         r_cnt    <= zero ? SLOT_W'(1) : r_cnt + 1'b1;
         r_sample <= 1'b0;
         if (zero)
            r_synced <= 1'b1;
         if (w_active) begin
            r_acc_l <= w_sum_l;
            r_acc_r <= w_sum_r;
            if (w_last) begin
               r_left   <= w_sat_l;
               r_right  <= w_sat_r;
               r_sample <= 1'b1;
            end
         end
      end
   end

   assign left   = r_left;
   assign right  = r_right;
   assign sample = r_sample;

endmodule

// File: doc/jt51_opacc.md
JT51_OPACC -- requirements
Module: jt51_opacc

Interface
REQ-001 SHALL have parameter OUT_W, default 16, meaning output sample width in bits (legal 14..19).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port cen, input, 1, clock enable; state advances only on clk edges where cen=1.
REQ-005 SHALL have port zero, input, 1, marks that op_in carries slot 0 of a 32-slot frame.
REQ-006 SHALL have port op_in, input, 14, signed operator output (two's complement) for the current slot.
REQ-007 SHALL have port con, input, 3, algorithm of the current slot's channel, aligned with op_in.
REQ-008 SHALL have port rl, input, 2, bit1 = right enable, bit0 = left enable of the current slot's channel.
REQ-009 SHALL have port ne, input, 1, noise enable, sampled while slot 31 is present.
REQ-010 SHALL have port noise_in, input, 14, signed noise sample used in place of op_in at slot 31 when ne=1.
REQ-011 SHALL have ports left and right, output, OUT_W each, signed saturated frame sums.
REQ-012 SHALL have port sample, output, 1, one-cen-cycle strobe marking updated left/right.

Function
REQ-013 SHALL keep a 5-bit slot counter: on a cen edge it loads 1 when zero=1, else increments modulo 32; the slot being processed equals 0 when zero=1, else the counter value.
REQ-014 SHALL decode slot s as group g=s[4:3] (0=M1, 1=M2, 2=C1, 3=C2) and channel s[2:0].
REQ-015 SHALL treat a slot as a carrier by con: 0-3 -> C2 only; 4 -> C1,C2; 5,6 -> M2,C1,C2; 7 -> all four groups.
REQ-016 SHALL sign-extend the contribution (op_in, or noise_in when s=31 and ne=1) to 19 bits and add it to accL if carrier and rl[0]=1, and to accR if carrier and rl[1]=1.
REQ-017 SHALL, at slot 0, load each accumulator with that slot's contribution (or 0), discarding the previous sum.
REQ-018 SHALL, on the cen edge processing slot 31, load left/right with saturate(acc + slot-31 contribution) and assert sample for exactly that following cen period; latency from the slot-31 input to output = 1 cen edge.
REQ-019 SHALL saturate by taking the 19-bit sum >> (19-OUT_W) arithmetically... no: SHALL clamp the 19-bit sum to [-2^(OUT_W-1), 2^(OUT_W-1)-1] without shifting.
REQ-020 SHALL size accumulators at 19 bits so that 32 contributions of -8192 (-262144) and of +8191 never wrap.
REQ-021 SHALL hold left/right between strobes; sample deasserts on the next cen edge.
REQ-022 SHALL keep a synced flag, cleared by reset, set on first zero=1; sample SHALL NOT assert and outputs SHALL stay 0 while synced=0.
REQ-023 SHALL, when zero=1 arrives while the counter is not 0 (early resync), discard the partial frame, restart at slot 0, and not strobe sample for the aborted frame.
REQ-024 SHALL ignore all inputs on edges with cen=0 (no state change, sample held).

Reset
REQ-025 SHALL, while rst=0, force counter=0, accL=accR=0, left=right=0, sample=0, synced=0, asynchronously.
REQ-026 SHALL resume on the first cen edge after rst release; a frame interrupted by reset SHALL never produce a strobe.

Structure
REQ-027 SHALL take constants SLOTS=32, ACC_W=19, OP_W=14 and the 8x4 carrier table from the shared package jt51_pkg.
REQ-028 SHALL instantiate one combinational sub-module jt51_opacc_sat (parameters IN_W, OUT_W) used twice, for left and right.

Verification
REQ-029 con=7, rl=3, op_in=+100 all slots, zero at slot 0 -> left=right=+3200, sample high one cen period after slot 31.
REQ-030 con=0, rl=1, op_in=+8191 on C2 slots, +5000 elsewhere -> left=65528 clamps to +32767, right=0.
REQ-031 con=7, rl=3, op_in=-8192 all slots -> acc=-262144 without wrap, left=right=-32768.
REQ-032 con=4, rl=2, ne=1, noise_in=-50, op_in=+10 all slots -> right=16*10-10-50=100, left=0.
REQ-033 zero re-asserted at slot 20 -> no strobe for aborted frame, next strobe 32 slots later with correct sum; rst=0 mid-frame -> outputs 0, no strobe until a full frame after next zero.
REQ-034 cen toggling 1-of-3 with constant stimulus -> results identical to cen=1 run, sample width exactly one cen period.

Note: REQ-019 final rule is the clamp without shifting; the shift clause is void.
